// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported unified memory bus between the instruction-fetch
//   requester and the data (MEM-stage) requester. One bus transaction is
//   outstanding at a time. Data has fixed priority over fetch. A fetch that a
//   branch redirect invalidates still completes on the bus, but its response
//   is swallowed. A WAIT phase that lasts too long is closed with a zero
//   response and a bus_err pulse.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   if_req_i / if_addr_i   fetch request (held until if_valid_o)
//   if_valid_o / if_rdata_o  one-cycle fetch response
//   mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i  data request
//   mem_valid_o / mem_rdata_o  one-cycle data response (load data / store ack)
//   flush_i                branch redirect, invalidates an outstanding fetch
//   bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o  bus request side
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i                    bus response side
//   stall_if_o, stall_mem_o  combinational stall requests to the hazard unit
//   bus_err_o              one-cycle pulse on a timeout completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_valid_o,
    output logic [31:0]   if_rdata_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [31:0]   mem_wdata_i,
    input  logic [3:0]    mem_be_i,
    output logic          mem_valid_o,
    output logic [31:0]   mem_rdata_o,
    input  logic          flush_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [31:0]   bus_wdata_o,
    output logic [3:0]    bus_be_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [31:0]   bus_rdata_i,
    output logic          stall_if_o,
    output logic          stall_mem_o,
    output logic          bus_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Counter only needs to reach TIMEOUT-1: the terminal WAIT cycle is the
    // one in which the count already equals TIMEOUT-1.
    localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            owner_mem_q, owner_mem_d;   // 1 = data owns the bus
    logic            drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_be_q, bus_be_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic            mem_valid_q, mem_valid_d;
    logic [31:0]     mem_rdata_q, mem_rdata_d;
    logic            bus_err_q, bus_err_d;

    logic            mem_elig;
    logic            if_elig;
    logic            to_hit;
    logic            fetch_killed;
    logic [31:0]     rsp_data;

    // A requester is not eligible in its own valid cycle, so a held request
    // is not re-issued. A fetch flushed in the arbitration cycle is stale.
    assign mem_elig     = mem_req_i & ~mem_valid_q;
    assign if_elig      = if_req_i & ~if_valid_q & ~flush_i;
    assign to_hit       = TO_EN && (cnt_q == TO_LAST);
    // A flush arriving in the very completion cycle also kills the response.
    assign fetch_killed = drop_q | flush_i;
    assign rsp_data     = bus_rvalid_i ? bus_rdata_i : 32'h0;

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_valid_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (mem_elig) begin
                    owner_mem_d = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                    bus_be_d    = mem_be_i;
                    bus_req_d   = 1'b1;
                    state_d     = ISSUE;
                end else if (if_elig) begin
                    owner_mem_d = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = 32'h0;
                    bus_be_d    = 4'hF;
                    bus_req_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                // bus_rvalid_i here is a bus protocol violation and is ignored.
                if (flush_i && !owner_mem_q) begin
                    drop_d = 1'b1;
                end
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                if (bus_rvalid_i || to_hit) begin
                    state_d   = IDLE;
                    drop_d    = 1'b0;
                    bus_err_d = ~bus_rvalid_i;
                    if (owner_mem_q) begin
                        mem_valid_d = 1'b1;
                        mem_rdata_d = rsp_data;
                    end else if (!fetch_killed) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rsp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (flush_i && !owner_mem_q) begin
                        drop_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_mem_q <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
            bus_be_q    <= 4'h0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_valid_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;
    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_rdata_o = mem_rdata_q;
    assign bus_err_o   = bus_err_q;

    // IF also holds while a killed fetch is still draining from the bus.
    assign stall_mem_o = mem_req_i & ~mem_valid_q;
    assign stall_if_o  = (if_req_i & ~if_valid_q) | (~owner_mem_q & drop_q);

endmodule
